handshake_constant_table: RTL
=============================

# handshake_constant_table

Parametrised constant source for the elastic dataflow fabric. It emits one constant per accepted control token and replaces fixed single-value constant units. The constant comes from a compile-time table of DEPTH entries and is selected in one of two modes: always entry 0, or cycling through the table with wrap-around. The output is registered, giving one-cycle latency, full throughput and a registered `outs` / `outs_valid`, so the block can break combinational valid paths between dataflow stages.

## Interface
- DATA_WIDTH, 32, width of each constant and of `outs`.
- DEPTH, 4, number of table entries; legal range 1..256.
- TABLE, all-zero, packed DEPTH*DATA_WIDTH vector; entry i = TABLE[i*DATA_WIDTH +: DATA_WIDTH].
- CYCLE, 1, 0 = always emit entry 0; 1 = advance one entry per accepted token, wrapping DEPTH-1 -> 0.
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset: one clock, asynchronous and active-high.
- ctrl_valid  input  1  control token present.
- ctrl_ready  output  1  block can accept a control token this cycle.
- restart  input  1  single-cycle pulse; index returns to 0.
- outs  output  DATA_WIDTH  emitted constant (registered).
- outs_valid  output  1  `outs` holds a token (registered).
- outs_last  output  1  emitted entry was index DEPTH-1 (registered).
- outs_ready  input  1  downstream accepts the token.

## Operation
- Internal state:
  - `idx`, width max(1, clog2(DEPTH)), reset 0.
  - Output register holding `outs`, `outs_valid` and `outs_last`.
- Accept condition: acc = ctrl_valid & ctrl_ready.
- ctrl_ready = ~rst & (~outs_valid | outs_ready). It is combinational from `outs_ready`; there is no combinational path from `ctrl_valid`.
- Selected entry: sel = restart ? 0 : idx.
- On acc, the register loads:
  - outs <= TABLE[sel]
  - outs_valid <= 1
  - outs_last <= (sel == DEPTH-1)
- Index update, CYCLE=1:
  - On acc: idx <= (sel == DEPTH-1) ? 0 : sel+1.
  - Otherwise, if restart: idx <= 0.
  - Wrap is an explicit compare, so it is correct for DEPTH that is not a power of two.
- Index update, CYCLE=0: idx stays 0. `outs_last` is 1 only when DEPTH=1.
- Token leaves when outs_valid & outs_ready & ~acc: outs_valid <= 0. `outs` and `outs_last` hold their last value.
- Simultaneous drain and accept (outs_valid & outs_ready & acc): the register reloads with the new token and outs_valid stays 1.
- restart and acc in the same cycle: restart has priority. The token emits entry 0 and idx becomes 1 (0 if DEPTH=1).
- Backpressure: while outs_valid & ~outs_ready, the register, `outs`, `outs_last` and idx are frozen and ctrl_ready = 0. A restart arriving during backpressure still clears idx.

## Timing
- Reset values (asynchronous, immediate on rst rise): outs = 0, outs_valid = 0, outs_last = 0, idx = 0. ctrl_ready = 0 while rst = 1.
- Latency: a token accepted at edge N appears on `outs` / `outs_valid` after edge N.
- Throughput: one token per cycle when outs_ready is held at 1.
- After a drain-only edge, ctrl_ready = 1 in the following cycle.
- Reset mid-stream: any in-flight output token is dropped and idx returns to 0. The first token after rst falls emits entry 0.
- Handshake rules:
  - `outs` and `outs_last` are stable while outs_valid & ~outs_ready.
  - outs_valid never falls without a handshake, except on reset.

## Structure
- Shared package `handshake_pkg`:
  - Function `idx_width(depth)` returning max(1, clog2(depth)).
  - Mode constants CONST_MODE_FIXED = 0 and CONST_MODE_CYCLE = 1.
- Sub-module `handshake_out_reg`: a parametrised one-slot output register with data/valid/ready, holding the `outs` and `outs_last` payload.
- The top level holds only the index counter, the table mux and the ctrl_ready/acc logic.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=3, TABLE={8'h33,8'h22,8'h11}, CYCLE=1 unless stated otherwise.
- **Basic sequence:** reset, then 5 tokens with outs_ready=1 held -> outs = 11, 22, 33, 11, 22 on consecutive cycles. outs_last = 0, 0, 1, 0, 0. One-cycle latency per token.
- **Backpressure:** outs_ready=0 for 4 cycles with ctrl_valid=1 -> first token 11 is held stable, ctrl_ready=0 and idx is frozen. After release, outs = 22 then 33 with no token lost or duplicated.
- **Restart:**
  - Restart pulse after two emissions (idx=2), no token that cycle -> next token emits 11.
  - Restart together with an accept at idx=1 -> emits 11, and the next token emits 22.
- **Fixed mode:** CYCLE=0, 4 tokens -> outs = 11 every time, outs_last = 0 throughout. DEPTH=1 with CYCLE=0 -> outs_last = 1 every time.
- **Reset mid-stream:** assert rst asynchronously while outs_valid=1 (idx=2) -> outs_valid = 0, outs = 0 and ctrl_ready = 0 immediately. After release, the first token emits 11.
- **Random stall soak:** 1000 tokens with random ctrl_valid and outs_ready -> output stream equals (11, 22, 33) repeated. No data or outs_last change while stalled.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake dataflow blocks: index sizing and constant-source modes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package handshake_pkg;

    // Constant-source selection modes.
    localparam int CONST_MODE_FIXED = 0;   // always emit entry 0
    localparam int CONST_MODE_CYCLE = 1;   // walk the table, wrapping at DEPTH-1

    // Largest table a constant source may carry.
    localparam int CONST_DEPTH_MAX = 256;

    // Width of an index able to address 'depth' entries; never narrower than one bit,
    // so a single-entry table still has a real (constant-zero) index register.
    function automatic int idx_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/handshake_constant_table_if.sv
// Handshake bundle of the constant source: control token in, constant token out.
// Latency: n/a (signal bundle only).
// Backpressure: outs_ready from the consumer gates ctrl_ready back to the producer.
//
// Signals:
//   ctrl_valid / ctrl_ready : control token handshake (producer -> block)
//   restart                 : single-cycle pulse returning the table index to 0
//   outs / outs_valid       : emitted constant and its valid (block -> consumer)
//   outs_last               : emitted constant was the final table entry
//   outs_ready              : consumer accepts the output token
interface handshake_constant_table_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ctrl_valid;
    logic                  ctrl_ready;
    logic                  restart;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_last;
    logic                  outs_ready;

    // Producer/consumer side (drives tokens in, takes constants out).
    modport master (
        output ctrl_valid,
        output restart,
        output outs_ready,
        input  ctrl_ready,
        input  outs,
        input  outs_valid,
        input  outs_last
    );

    // Constant source side.
    modport slave (
        input  ctrl_valid,
        input  restart,
        input  outs_ready,
        output ctrl_ready,
        output outs,
        output outs_valid,
        output outs_last
    );
endinterface

// File: rtl/handshake_out_reg.sv
// One-slot registered output stage carrying a WIDTH-bit payload with valid/ready.
// Latency: 1 cycle from accepted input to out_valid; full throughput with out_ready held high.
// Backpressure: in_ready = ~rst & (~out_valid | out_ready); payload frozen while stalled.
//
// Ports:
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake; in_data loaded when both are high
//   out_valid/out_ready   : downstream handshake; out_data is the registered payload
module handshake_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic load;

    // Slot is free when empty or when its current token leaves at this edge.
    // Held low during reset so no token is taken while the slot is being cleared.
    assign in_ready = ~rst & (~out_valid | out_ready);
    assign load     = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            // Covers both fill-from-empty and drain-and-refill in the same cycle.
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            // Drain only; payload keeps its last value for observability.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/handshake_constant_table.sv
// Constant source: emits one table entry per accepted control token, fixed or cycling.
// Latency: 1 cycle (registered outs/outs_valid/outs_last); one token per cycle at full rate.
// Backpressure: ctrl_ready = ~rst & (~outs_valid | outs_ready); index frozen while stalled.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; clears output slot and index
//   bus  : handshake_constant_table_if.slave (ctrl_valid/ctrl_ready, restart,
//          outs/outs_valid/outs_last/outs_ready)
module handshake_constant_table
    import handshake_pkg::*;
#(
    parameter int                          DATA_WIDTH = 32,
    parameter int                          DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0] TABLE      = '0,
    parameter int                          CYCLE      = CONST_MODE_CYCLE
) (
    input  logic                        clk,
    input  logic                        rst,
    handshake_constant_table_if.slave   bus
);

    localparam int             IW       = idx_width(DEPTH);
    localparam int             SLOTS    = 1 << IW;
    localparam logic [IW-1:0]  LAST_IDX = IW'(DEPTH - 1);

    if (DEPTH < 1 || DEPTH > CONST_DEPTH_MAX) begin : g_bad_depth
        $error("handshake_constant_table: DEPTH must be in 1..256");
    end
    if (CYCLE != CONST_MODE_FIXED && CYCLE != CONST_MODE_CYCLE) begin : g_bad_mode
        $error("handshake_constant_table: CYCLE must be 0 or 1");
    end

    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nxt;
    logic [IW-1:0]         sel;
    logic                  sel_last;
    logic                  acc;
    logic                  slot_ready;
    logic [DATA_WIDTH-1:0] entries [SLOTS];
    logic [DATA_WIDTH:0]   in_payload;
    logic [DATA_WIDTH:0]   out_payload;

    // Table unpacked into a power-of-two array so the index never selects
    // outside the array; padding slots are unreachable because the index
    // wraps explicitly at DEPTH-1.
    for (genvar i = 0; i < SLOTS; i++) begin : g_entries
        if (i < DEPTH) begin : g_used
            assign entries[i] = TABLE[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign entries[i] = '0;
        end
    end

    // Restart wins over the stored index for the token accepted this cycle.
    assign sel      = bus.restart ? '0 : idx;
    assign sel_last = (sel == LAST_IDX);

    assign bus.ctrl_ready = slot_ready;
    assign acc            = bus.ctrl_valid & slot_ready;

    assign in_payload = {sel_last, entries[sel]};

    always_comb begin
        idx_nxt = idx;
        if (CYCLE == CONST_MODE_CYCLE) begin
            if (acc) begin
                idx_nxt = sel_last ? '0 : sel + IW'(1);
            end else if (bus.restart) begin
                // Restart without a token (including during a stall) still rewinds.
                idx_nxt = '0;
            end
        end else begin
            idx_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else begin
            idx <= idx_nxt;
        end
    end

    handshake_out_reg #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.ctrl_valid),
        .in_ready  (slot_ready),
        .in_data   (in_payload),
        .out_valid (bus.outs_valid),
        .out_ready (bus.outs_ready),
        .out_data  (out_payload)
    );

    assign bus.outs_last = out_payload[DATA_WIDTH];
    assign bus.outs      = out_payload[DATA_WIDTH-1:0];

endmodule
